// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, run limit and response-state encoding for mem_arbiter
package mem_arbiter_pkg;
   localparam int ARB_DATA_WIDTH   = 32;
   localparam int ARB_ADDR_WIDTH   = 16;
   localparam int ARB_MAX_DATA_RUN = 4;
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IF   = 2'd1,
      ARB_DRD  = 2'd2
   } arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between fetch and load/store ports with starvation-bounded data priority
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
   parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
   parameter int MAX_DATA_RUN = ARB_MAX_DATA_RUN
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);
   arb_state_t state, state_nx;
   logic [3:0] run_cnt, run_nx;
   logic       fetch_prio;
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ARB_IDLE;
         run_cnt <= '0;
      end else begin
         state   <= state_nx;
         run_cnt <= run_nx;
      end
   end
   always_comb begin
      fetch_prio = if_req && (run_cnt >= MAX_RUN);
      d_gnt      = !reset && d_req && !fetch_prio;
      if_gnt     = !reset && if_req && !d_gnt;
      mem_en     = if_gnt || d_gnt;
      mem_we     = d_gnt && d_we;
      mem_addr   = d_gnt ? d_addr : if_gnt ? if_addr : '0;
      mem_wdata  = d_gnt ? d_wdata : '0;
      state_nx   = if_gnt ? ARB_IF : (d_gnt && !d_we) ? ARB_DRD : ARB_IDLE;
      run_nx     = (!if_req || if_gnt) ? 4'd0 : (d_gnt && run_cnt < MAX_RUN) ? run_cnt + 4'd1 : run_cnt;
      // a reset arriving while a read is in flight drops its response
      if_rvalid  = !reset && (state == ARB_IF);
      d_rvalid   = !reset && (state == ARB_DRD);
      if_rdata   = if_rvalid ? mem_rdata : '0;
      d_rdata    = d_rvalid ? mem_rdata : '0;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small synchronous-read memory model
module tb_mem_arbiter;
   logic        clk = 0;
   logic        reset;
   logic        if_req, if_gnt, if_rvalid;
   logic [15:0] if_addr;
   logic [31:0] if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [15:0] d_addr;
   logic [31:0] d_wdata, d_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [31:0] mem [0:255];
   int          n_chk = 0;
   int          n_fail = 0;
   logic        pend_if = 0, pend_d = 0;
   logic        prev_f, prev_d;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
   end

   // requests must stay asserted until granted
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(pend_if && !if_req)) else $error("fetch request withdrawn before grant");
         assert (!(pend_d && !d_req)) else $error("data request withdrawn before grant");
      end
      pend_if <= !reset && if_req && !if_gnt;
      pend_d  <= !reset && d_req && !d_gnt;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'h00500093;
      mem[8'h30] = 32'h13572468;
      mem_rdata = '0;
      reset = 1;
      if_req = 1; if_addr = 16'h10;
      d_req = 1; d_we = 0; d_addr = 16'h30; d_wdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_outs", {26'd0, if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid}, 32'd0);
         check("rst_addr_wdata", {mem_addr, mem_wdata[15:0]} | {16'd0, mem_wdata[31:16]}, 32'd0);
         check("rst_rdata", if_rdata | d_rdata, 32'd0);
      end
      reset = 0;
      #1;
      check("rel_if_gnt", {31'd0, if_gnt}, 32'd0);
      check("rel_d_gnt", {31'd0, d_gnt}, 32'd1);
      check("rel_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      tick();
      d_req = 0;
      #1;
      check("rel_load_rvalid", {31'd0, d_rvalid}, 32'd1);
      check("rel_load_rdata", d_rdata, 32'h13572468);
      check("fetch_gnt", {31'd0, if_gnt}, 32'd1);
      check("fetch_addr", {16'd0, mem_addr}, 32'h10);
      check("fetch_we", {31'd0, mem_we}, 32'd0);
      tick();
      if_req = 0;
      #1;
      check("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
      check("fetch_rdata", if_rdata, 32'h00500093);
      check("fetch_no_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      check("idle_mem_en", {31'd0, mem_en}, 32'd0);
      check("idle_mem_addr", {16'd0, mem_addr}, 32'd0);

      tick();
      d_req = 1; d_we = 1; d_addr = 16'h20; d_wdata = 32'hDEADBEEF;
      #1;
      check("st_gnt", {31'd0, d_gnt}, 32'd1);
      check("st_mem_we", {31'd0, mem_we}, 32'd1);
      check("st_mem_addr", {16'd0, mem_addr}, 32'h20);
      check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
      tick();
      d_we = 0; d_wdata = 32'h0;
      #1;
      check("st_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      check("ld_gnt", {31'd0, d_gnt}, 32'd1);
      check("ld_mem_we", {31'd0, mem_we}, 32'd0);
      tick();
      d_req = 0;
      #1;
      check("ld_rvalid", {31'd0, d_rvalid}, 32'd1);
      check("ld_rdata", d_rdata, 32'hDEADBEEF);
      tick();
      check("ld_rvalid_once", {31'd0, d_rvalid}, 32'd0);

      if_req = 1; if_addr = 16'h10;
      d_req = 1; d_we = 0; d_addr = 16'h20;
      prev_f = 0; prev_d = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         check($sformatf("starve_if_gnt_%0d", c), {31'd0, if_gnt}, {31'd0, c % 5 == 4});
         check($sformatf("starve_d_gnt_%0d", c), {31'd0, d_gnt}, {31'd0, c % 5 != 4});
         check($sformatf("starve_rvalid_%0d", c), {30'd0, if_rvalid, d_rvalid}, {30'd0, prev_f, prev_d});
         check($sformatf("starve_rdata_%0d", c), if_rdata | d_rdata, prev_f ? 32'h00500093 : prev_d ? 32'hDEADBEEF : 32'h0);
         prev_f = (c % 5 == 4);
         prev_d = (c % 5 != 4);
         tick();
      end
      d_req = 0;
      #1;
      check("starve_tail_if_gnt", {31'd0, if_gnt}, 32'd1);
      check("starve_tail_d_rvalid", {31'd0, d_rvalid}, 32'd1);
      tick();
      if_req = 0;
      #1;
      check("starve_tail_if_rvalid", {31'd0, if_rvalid}, 32'd1);
      tick();

      if_req = 1; if_addr = 16'h10;
      #1;
      check("bb_f1_gnt", {30'd0, if_gnt, d_gnt}, 32'b10);
      tick();
      d_req = 1; d_we = 0; d_addr = 16'h30;
      #1;
      check("bb_d_gnt", {30'd0, if_gnt, d_gnt}, 32'b01);
      check("bb_rv1", {30'd0, if_rvalid, d_rvalid}, 32'b10);
      check("bb_rd1", if_rdata, 32'h00500093);
      tick();
      d_req = 0;
      #1;
      check("bb_f2_gnt", {30'd0, if_gnt, d_gnt}, 32'b10);
      check("bb_rv2", {30'd0, if_rvalid, d_rvalid}, 32'b01);
      check("bb_rd2", d_rdata, 32'h13572468);
      check("bb_if_rdata_zero", if_rdata, 32'h0);
      tick();
      if_req = 0;
      #1;
      check("bb_rv3", {30'd0, if_rvalid, d_rvalid}, 32'b10);
      check("bb_rd3", if_rdata, 32'h00500093);
      tick();

      d_req = 1; d_we = 0; d_addr = 16'h30;
      #1;
      check("mid_ld_gnt", {31'd0, d_gnt}, 32'd1);
      tick();
      d_req = 0; reset = 1;
      #1;
      check("mid_rst_rvalid0", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      check("mid_rst_rdata0", d_rdata, 32'h0);
      tick();
      reset = 0;
      #1;
      check("mid_rst_rvalid1", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      tick();
      check("mid_rst_rvalid2", {30'd0, if_rvalid, d_rvalid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
